vga_timing_gen: RTL

Generates 640x480@60 Hz VGA raster timing from the system clock and drives the monitor pins. Sits upstream of the video-memory wrapper: it supplies the raw column/row read coordinates to the wrapper. It also sits downstream of it: it takes the wrapper's registered RGB back, aligns the sync pulses to it through a configurable delay line, and blanks the colour outside the visible window.

---
 rtl/vga_timing_gen.sv | 110 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster timing: pixel divider, column/row counters, sync decode,
// sync/blank delay line matching the colour source latency, and registered DAC outputs.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [2:0]  iRGB,
    output logic [10:0] oCol,
    output logic [9:0]  oRow,
    output logic        oPixelEn,
    output logic        oFrameStart,
    output logic        oHSync,
    output logic        oVSync,
    output logic [2:0]  oRGB
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned PW       = 3 * PIPE_DELAY;

    logic [3:0]  r_div;
    logic [10:0] r_col;
    logic [9:0]  r_row;
    logic        r_hsync;
    logic        r_vsync;
    logic [2:0]  r_rgb;

    logic        w_pix_en;
    logic        w_hs_n;
    logic        w_vs_n;
    logic        w_vis;
    logic [2:0]  w_decode;
    logic [2:0]  w_tap;

    assign w_pix_en = (r_div == 4'(CLK_DIV - 1));

    // Pixel divider and raster counters
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_div <= 4'd0;
            r_col <= 11'd0;
            r_row <= 10'd0;
        end else begin
            r_div <= w_pix_en ? 4'd0 : r_div + 4'd1;
            if (w_pix_en) begin
                if (r_col == 11'(H_TOTAL - 1)) begin
                    r_col <= 11'd0;
                    r_row <= (r_row == 10'(V_TOTAL - 1)) ? 10'd0 : r_row + 10'd1;
                end else begin
                    r_col <= r_col + 11'd1;
                end
            end
        end
    end

    assign w_hs_n   = !((r_col >= 11'(HS_START)) && (r_col < 11'(HS_END)));
    assign w_vs_n   = !((r_row >= 10'(VS_START)) && (r_row < 10'(VS_END)));
    assign w_vis    = (r_col < 11'(H_VISIBLE)) && (r_row < 10'(V_VISIBLE));
    assign w_decode = {w_hs_n, w_vs_n, w_vis};

    // Sync/visible delay line, one 3-bit stage per CLK of colour source latency
    if (PIPE_DELAY == 0) begin : g_nopipe
        assign w_tap = w_decode;
    end else begin : g_pipe
        logic [PW-1:0] r_pipe;
        always_ff @(posedge CLK) begin
            if (Reset) begin
                r_pipe <= {PIPE_DELAY{3'b110}};
            end else begin
                r_pipe <= (r_pipe << 3) | PW'(w_decode);
            end
        end
        assign w_tap = r_pipe[PW-1 -: 3];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 3'b000;
        end else begin
            r_hsync <= w_tap[2];
            r_vsync <= w_tap[1];
            r_rgb   <= w_tap[0] ? iRGB : 3'b000;
        end
    end

    assign oCol        = r_col;
    assign oRow        = r_row;
    assign oPixelEn    = w_pix_en;
    assign oFrameStart = (r_div == 4'd0) && (r_col == 11'd0) && (r_row == 10'd0);
    assign oHSync      = r_hsync;
    assign oVSync      = r_vsync;
    assign oRGB        = r_rgb;

endmodule
